// File: rtl/gb_frame_sequencer.sv
// APU frame sequencer: divides the system clock to the 512 Hz frame tick, steps the
// 8-step length/sweep/envelope schedule, and stretches channel triggers into 2-cycle starts.
module gb_frame_sequencer #(
  parameter int TICK_DIVIDER = 8192
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apu_enable,
  input  logic       div_reset,
  input  logic [3:0] trigger,
  output logic       clk_length_ctr,
  output logic       clk_sweep,
  output logic       clk_vol_env,
  output logic [3:0] start,
  output logic [2:0] frame_step,
  output logic       length_clk_next
);

  localparam int PW = $clog2(TICK_DIVIDER);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVIDER - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIVIDER / 2);

  typedef enum logic [2:0] {
    STEP0 = 3'd0, STEP1 = 3'd1, STEP2 = 3'd2, STEP3 = 3'd3,
    STEP4 = 3'd4, STEP5 = 3'd5, STEP6 = 3'd6, STEP7 = 3'd7
  } step_e;

  logic [PW-1:0]   prescaler_q, prescaler_d;
  step_e           step_q, step_d;
  logic            len_q, len_d;
  logic            sweep_q, sweep_d;
  logic            env_q, env_d;
  logic [3:0][1:0] cnt_q, cnt_d;
  logic [3:0]      start_q, start_d;
  logic            natural_tick;
  logic            div_tick;
  logic            tick;

  // A DIV write only produces a tick when it drops DIV's frame bit from 1 to 0,
  // i.e. when the prescaler is in its upper half; a coincident natural tick stays single.
  always_comb begin
    natural_tick = (prescaler_q == PRESC_LAST);
    div_tick     = div_reset && (prescaler_q >= PRESC_HALF);
    tick         = apu_enable && (natural_tick || div_tick);

    prescaler_d = prescaler_q + PW'(1);
    if (!apu_enable || div_reset || natural_tick) begin
      prescaler_d = '0;
    end

    step_d = step_q;
    if (!apu_enable) begin
      step_d = STEP0;
    end else if (tick) begin
      step_d = step_e'(step_q + 3'd1);
    end

    len_d   = tick && !step_q[0];
    sweep_d = tick && ((step_q == STEP2) || (step_q == STEP6));
    env_d   = tick && (step_q == STEP7);

    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!apu_enable) begin
        cnt_d[i] = 2'd0;
      end else if (trigger[i]) begin
        cnt_d[i] = 2'd2;
      end else if (cnt_q[i] != 2'd0) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
      start_d[i] = (cnt_d[i] != 2'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      step_q      <= STEP0;
      len_q       <= 1'b0;
      sweep_q     <= 1'b0;
      env_q       <= 1'b0;
      cnt_q       <= '0;
      start_q     <= 4'd0;
    end else begin
      prescaler_q <= prescaler_d;
      step_q      <= step_d;
      len_q       <= len_d;
      sweep_q     <= sweep_d;
      env_q       <= env_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
    end
  end

  assign clk_length_ctr  = len_q;
  assign clk_sweep       = sweep_q;
  assign clk_vol_env     = env_q;
  assign start           = start_q;
  assign frame_step      = step_q;
  // Lengths are clocked on even steps, so the next tick clocks length when the step is even.
  assign length_clk_next = ~step_q[0];

endmodule

// File: tb/tb_gb_frame_sequencer.sv
// Bench for gb_frame_sequencer with an 8-cycle frame tick; expected output vectors are
// queued as stimulus is applied and checked one cycle later after the clock edge.
module tb_gb_frame_sequencer;

  localparam int W = 11;

  logic       clk;
  logic       rst_n;
  logic       apu_enable;
  logic       div_reset;
  logic [3:0] trigger;
  logic       clk_length_ctr;
  logic       clk_sweep;
  logic       clk_vol_env;
  logic [3:0] start;
  logic [2:0] frame_step;
  logic       length_clk_next;

  logic [W-1:0] exp_q[$];
  int total;
  int bad;

  gb_frame_sequencer #(.TICK_DIVIDER(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .apu_enable      (apu_enable),
    .div_reset       (div_reset),
    .trigger         (trigger),
    .clk_length_ctr  (clk_length_ctr),
    .clk_sweep       (clk_sweep),
    .clk_vol_env     (clk_vol_env),
    .start           (start),
    .frame_step      (frame_step),
    .length_clk_next (length_clk_next)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [W-1:0] ev(input logic l, input logic s, input logic v,
                                      input logic [2:0] st, input logic [3:0] sr);
    return {l, s, v, st, sr, ~st[0]};
  endfunction

  function automatic logic [W-1:0] obs();
    return {clk_length_ctr, clk_sweep, clk_vol_env, frame_step, start, length_clk_next};
  endfunction

  task automatic test_reset();
    logic [W-1:0] e;
    logic [W-1:0] got;
    rst_n = 1'b0; apu_enable = 1'b1; div_reset = 1'b0; trigger = 4'd0;
    #3;
    e = ev(0, 0, 0, 3'd0, 4'd0);
    exp_q.push_back(e);
    got = obs();
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin bad++; $display("FAIL reset got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int k = 1; k <= 64; k++) begin
      logic [2:0] st;
      logic [2:0] s;
      logic       p;
      st = 3'((k / 8) % 8);
      s  = 3'((k / 8 - 1) % 8);
      p  = (k % 8 == 0);
      e  = ev(p && !s[0], p && (s == 3'd2 || s == 3'd6), p && (s == 3'd7), st, 4'd0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      got = obs();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL sequence k=%0d got=%b exp=%b", k, got, e); end
    end
  endtask

  task automatic test_div_reset();
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int i = 0; i < 25; i++) begin
      div_reset = (i == 5 || i == 16);
      if (i < 5)       e = ev(0, 0, 0, 3'd0, 4'd0);
      else if (i == 5) e = ev(1, 0, 0, 3'd1, 4'd0);
      else if (i < 13) e = ev(0, 0, 0, 3'd1, 4'd0);
      else if (i < 24) e = ev(0, 0, 0, 3'd2, 4'd0);
      else             e = ev(1, 1, 0, 3'd3, 4'd0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      div_reset = 1'b0;
      got = obs();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL div_reset i=%0d got=%b exp=%b", i, got, e); end
    end
  endtask

  task automatic test_div_coincide();
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int i = 0; i < 24; i++) begin
      div_reset = (i == 15);
      if (i < 7)        e = ev(0, 0, 0, 3'd3, 4'd0);
      else if (i < 15)  e = ev(0, 0, 0, 3'd4, 4'd0);
      else if (i == 15) e = ev(1, 0, 0, 3'd5, 4'd0);
      else if (i < 23)  e = ev(0, 0, 0, 3'd5, 4'd0);
      else              e = ev(0, 0, 0, 3'd6, 4'd0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      div_reset = 1'b0;
      got = obs();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL div_coincide i=%0d got=%b exp=%b", i, got, e); end
    end
  endtask

  task automatic test_trigger();
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int i = 0; i < 10; i++) begin
      case (i)
        2: trigger = 4'b0101;
        3: trigger = 4'b0001;
        7: trigger = 4'b1000;
        default: trigger = 4'b0000;
      endcase
      case (i)
        2, 3:    e = ev(0, 0, 0, 3'd6, 4'b0101);
        4:       e = ev(0, 0, 0, 3'd6, 4'b0001);
        7:       e = ev(1, 1, 0, 3'd7, 4'b1000);
        8:       e = ev(0, 0, 0, 3'd7, 4'b1000);
        9:       e = ev(0, 0, 0, 3'd7, 4'b0000);
        default: e = ev(0, 0, 0, 3'd6, 4'b0000);
      endcase
      exp_q.push_back(e);
      @(posedge clk); #1;
      trigger = 4'd0;
      got = obs();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL trigger i=%0d got=%b exp=%b", i, got, e); end
    end
  endtask

  task automatic test_disable();
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int i = 0; i < 20; i++) begin
      apu_enable = !(i >= 1 && i <= 11);
      if (i == 0)       trigger = 4'b0010;
      else if (i == 1)  trigger = 4'b1111;
      else if (i <= 11) trigger = 4'($urandom_range(0, 15));
      else              trigger = 4'd0;
      div_reset = (i >= 2 && i <= 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == 0)       e = ev(0, 0, 0, 3'd7, 4'b0010);
      else if (i < 19)  e = ev(0, 0, 0, 3'd0, 4'd0);
      else              e = ev(1, 0, 0, 3'd1, 4'd0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      trigger = 4'd0; div_reset = 1'b0;
      got = obs();
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin bad++; $display("FAIL disable i=%0d got=%b exp=%b", i, got, e); end
    end
    apu_enable = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int i = 0; i < 56; i++) begin
      trigger = (i == 54) ? 4'b0100 : 4'd0;
      if (i == 55) exp_q.push_back(ev(0, 0, 1, 3'd0, 4'b0100));
      @(posedge clk); #1;
      trigger = 4'd0;
      if (i == 55) begin
        got = obs();
        e = exp_q.pop_front();
        total++;
        if (got !== e) begin bad++; $display("FAIL env_pulse got=%b exp=%b", got, e); end
      end
    end
    #2;
    rst_n = 1'b0;
    exp_q.push_back(ev(0, 0, 0, 3'd0, 4'd0));
    #1;
    got = obs();
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin bad++; $display("FAIL async_reset got=%b exp=%b", got, e); end
  endtask

  task automatic test_envelope();
    int   len_cnt, sw_cnt, env_cnt, consec;
    logic prev_any, any;
    logic [3:0] vol;
    len_cnt = 0; sw_cnt = 0; env_cnt = 0; consec = 0; prev_any = 1'b0; vol = 4'd0;
    @(posedge clk); #1;
    rst_n = 1'b1; apu_enable = 1'b1;
    for (int k = 1; k <= 960; k++) begin
      @(posedge clk); #1;
      any = clk_length_ctr | clk_sweep | clk_vol_env;
      if (any && prev_any) consec++;
      prev_any = any;
      if (clk_length_ctr) len_cnt++;
      if (clk_sweep) sw_cnt++;
      if (clk_vol_env) begin
        env_cnt++;
        if (vol != 4'hf) vol = vol + 4'd1;
      end
    end
    total++;
    if (vol !== 4'hf) begin bad++; $display("FAIL env_volume got=%0d exp=15", vol); end
    total++;
    if (env_cnt != 15) begin bad++; $display("FAIL env_count got=%0d exp=15", env_cnt); end
    total++;
    if (len_cnt != 60) begin bad++; $display("FAIL len_count got=%0d exp=60", len_cnt); end
    total++;
    if (sw_cnt != 30) begin bad++; $display("FAIL sweep_count got=%0d exp=30", sw_cnt); end
    total++;
    if (consec != 0) begin bad++; $display("FAIL back_to_back got=%0d exp=0", consec); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0; apu_enable = 1'b0; div_reset = 1'b0; trigger = 4'd0;
    test_reset();
    test_sequence();
    test_div_reset();
    test_div_coincide();
    test_trigger();
    test_disable();
    test_async_reset();
    test_envelope();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gb_frame_sequencer.md
# gb_frame_sequencer

APU frame sequencer and channel-trigger scheduler. Derives the 512 Hz frame tick from the system clock and steps an 8-state sequence that issues one-cycle clock enables to the length counters, the channel-1 frequency sweep and the volume envelopes (`gb_envelopeFunction.clk_vol_env`). It also converts per-channel trigger writes into the 2-cycle `start` pulses the channel blocks expect. One instance sits in the APU top, between the register file and the four channel datapaths.

## Interface
- `TICK_DIVIDER`, default 8192: `clk` cycles per frame tick (4.194304 MHz / 512). Must be even and ≥ 4.
- `clk`  in  1: system clock; all state on rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `apu_enable`  in  1: NR52 bit 7; low holds the sequencer idle.
- `div_reset`  in  1: one-cycle pulse on any CPU write to DIV.
- `trigger`  in  4: one-cycle trigger pulses, bit i = channel i+1 (NRx4 bit 7 write).
- `clk_length_ctr`  out  1: one-cycle length-counter clock enable.
- `clk_sweep`  out  1: one-cycle sweep clock enable.
- `clk_vol_env`  out  1: one-cycle envelope clock enable.
- `start`  out  4: per-channel start, high for 2 cycles per trigger.
- `frame_step`  out  3: current step 0–7.
- `length_clk_next`  out  1: next tick clocks length (`~frame_step[0]`), for length-enable quirk.

## Operation
- Reset: prescaler 0, `frame_step` 0, all pulse outputs 0, `start` 0.
- Prescaler counts 0..`TICK_DIVIDER`-1 while `apu_enable`=1, wraps to 0. Natural tick = prescaler at `TICK_DIVIDER`-1.
- `div_reset`: prescaler ← 0. If enabled and prescaler ≥ `TICK_DIVIDER`/2 (DIV bit high, falling edge), a tick is generated that cycle. Natural tick and `div_reset` in same cycle → exactly one tick.
- On a tick at step s: step ← s+1 (mod 8); pulses per s:
  - s=0,4: `clk_length_ctr`.
  - s=2,6: `clk_length_ctr` and `clk_sweep`.
  - s=7: `clk_vol_env`.
  - s=1,3,5: none.
- `apu_enable`=0: prescaler and step forced to 0, all pulses 0, `start` cleared, `trigger` ignored. On re-enable, sequence restarts at step 0.
- Triggers: `trigger[i]` sets a per-channel 2-cycle down-counter; `start[i]` high while counter ≠ 0. Retrigger while active reloads (start stays high 2 cycles after last trigger). Channels independent; triggers do not affect sequencer timing.
- Pulse outputs never assert in two consecutive cycles.

## Timing
- All outputs registered. Tick detected at edge E → pulse visible from E to E+1 only; `frame_step` updates at E.
- After reset release with `apu_enable`=1, first tick at the `TICK_DIVIDER`-th rising edge; pulses every `TICK_DIVIDER` cycles thereafter.
- Full sequence period: 8·`TICK_DIVIDER` cycles: 4 length, 2 sweep, 1 envelope pulse.
- `trigger` sampled at edge T → `start[i]` high for edges T..T+2 window (two full cycles), low after T+2.
- `rst_n` low at any time (including mid-pulse, mid-`start`) clears all outputs immediately, without waiting for `clk`.
- `apu_enable` falling: outputs and step cleared at next edge.

## Test plan
- `TICK_DIVIDER`=8, reset, enable: `clk_length_ctr` high exactly in cycle 8, `frame_step` 0→1; no other pulses.
- Run 64 cycles: length pulses at steps 0,2,4,6 (cycles 8,24,40,56), sweep at 24,56, `clk_vol_env` only at 64; `length_clk_next` tracks `~frame_step[0]`.
- `div_reset` at prescaler 5: immediate extra tick, step+1, prescaler 0, next natural tick 8 cycles later; at prescaler 2: no tick, prescaler 0.
- `div_reset` coinciding with natural tick: single pulse, step advances by 1.
- `trigger`=4'b0101 at cycle 3: `start`=4'b0101 for 2 cycles; retrigger ch1 one cycle later extends `start[0]` to 3 cycles total; ch3 unchanged.
- Drop `apu_enable` at step 5 → step 0, no pulses, triggers ignored; assert `rst_n`=0 during `clk_vol_env` high → cleared asynchronously. Chained `gb_envelopeFunction` (vol 0, increasing, sweep 1) reaches 4'b1111 after 15 envelope pulses.
